// File: rtl/gen3_rx_block_aligner_if.sv
// Lane-side bundle for the Gen3 128b/130b block aligner: PIPE receive byte
// stream and LTSSM control in, aligned block stream and status out.
interface gen3_rx_block_aligner_if #(
  parameter int ERR_CNT_WIDTH = 8
);
  logic [7:0]               RxData;
  logic                     RxDataValid;
  logic                     RxStartBlock;
  logic [1:0]               RxSyncHeader;
  logic                     realign;

  logic [7:0]               blk_data;
  logic                     blk_valid;
  logic                     blk_start;
  logic                     blk_os;
  logic [1:0]               blk_sh;
  logic                     aligned;
  logic                     locked;
  logic                     sh_error;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  // PHY/LTSSM side: drives the receive stream, consumes aligned blocks.
  modport master (
    output RxData, RxDataValid, RxStartBlock, RxSyncHeader, realign,
    input  blk_data, blk_valid, blk_start, blk_os, blk_sh,
           aligned, locked, sh_error, err_cnt
  );

  // Aligner side.
  modport slave (
    input  RxData, RxDataValid, RxStartBlock, RxSyncHeader, realign,
    output blk_data, blk_valid, blk_start, blk_os, blk_sh,
           aligned, locked, sh_error, err_cnt
  );
endinterface

// File: rtl/gen3_rx_block_aligner.sv
// Per-lane Gen3 receive block aligner: acquires alignment on EIEOS, tracks
// 16-byte block boundaries, validates sync headers and forwards tagged bytes.
module gen3_rx_block_aligner #(
  parameter int ERR_LIMIT     = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  gen3_rx_block_aligner_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNALIGNED = 2'd0,
    ST_ALIGNED   = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  localparam logic [1:0]               SH_OS      = 2'b01;
  localparam logic [1:0]               SH_DATA    = 2'b10;
  localparam logic [7:0]               SDS_BYTE0  = 8'hE1;
  localparam logic [3:0]               LAST_BYTE  = 4'd15;
  localparam logic [3:0]               ERR_LIM_C  = 4'(ERR_LIMIT);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = '1;

  state_e                   state_q, state_d;
  logic [3:0]               byte_cnt_q, byte_cnt_d;
  logic [3:0]               bad_run_q, bad_run_d;
  logic                     chk_active_q, chk_active_d;

  logic [7:0]               blk_data_q, blk_data_d;
  logic                     blk_valid_q, blk_valid_d;
  logic                     blk_start_q, blk_start_d;
  logic                     blk_os_q, blk_os_d;
  logic [1:0]               blk_sh_q, blk_sh_d;
  logic                     aligned_q, aligned_d;
  logic                     locked_q, locked_d;
  logic                     sh_error_q, sh_error_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic                     eieos_start;
  logic                     eieos_byte_ok;
  logic                     sh_good;
  logic [3:0]               bad_run_inc;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_inc;

  assign eieos_start   = bus.RxStartBlock && (bus.RxSyncHeader == SH_OS) &&
                         (bus.RxData == 8'h00);
  assign eieos_byte_ok = (bus.RxData == (byte_cnt_q[0] ? 8'hFF : 8'h00));
  assign sh_good       = bus.RxStartBlock &&
                         ((bus.RxSyncHeader == SH_OS) || (bus.RxSyncHeader == SH_DATA));
  assign bad_run_inc   = bad_run_q + 4'd1;
  assign err_cnt_inc   = (err_cnt_q == ERR_CNT_MAX) ? err_cnt_q : err_cnt_q + 1'b1;

  // NOTE: every _d gets a default before any branch, so no path can leave a
  // variable unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    bad_run_d    = bad_run_q;
    chk_active_d = chk_active_q;
    blk_data_d   = blk_data_q;
    blk_valid_d  = 1'b0;
    blk_start_d  = 1'b0;
    blk_os_d     = blk_os_q;
    blk_sh_d     = blk_sh_q;
    sh_error_d   = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (bus.realign) begin
      state_d      = ST_UNALIGNED;
      byte_cnt_d   = '0;
      bad_run_d    = '0;
      chk_active_d = 1'b0;
      err_cnt_d    = '0;
    end else if (bus.RxDataValid) begin
      unique case (state_q)
        ST_UNALIGNED: begin
          // Any start marker (re)starts the EIEOS check, or aborts it if the
          // marked byte cannot be an EIEOS first byte.
          if (bus.RxStartBlock) begin
            chk_active_d = eieos_start;
            byte_cnt_d   = eieos_start ? 4'd1 : 4'd0;
          end else if (chk_active_q) begin
            if (!eieos_byte_ok) begin
              chk_active_d = 1'b0;
              byte_cnt_d   = '0;
            end else if (byte_cnt_q == LAST_BYTE) begin
              state_d      = ST_ALIGNED;
              chk_active_d = 1'b0;
              byte_cnt_d   = '0;
              bad_run_d    = '0;
            end else begin
              byte_cnt_d   = byte_cnt_q + 4'd1;
            end
          end
        end

        ST_ALIGNED, ST_LOCKED: begin
          if (bus.RxStartBlock && (byte_cnt_q != '0)) begin
            // Misplaced start: drop alignment and treat the byte as a
            // candidate EIEOS first byte.
            sh_error_d   = 1'b1;
            err_cnt_d    = err_cnt_inc;
            state_d      = ST_UNALIGNED;
            bad_run_d    = '0;
            chk_active_d = eieos_start;
            byte_cnt_d   = eieos_start ? 4'd1 : 4'd0;
          end else begin
            blk_valid_d = 1'b1;
            blk_data_d  = bus.RxData;
            blk_start_d = (byte_cnt_q == '0);
            byte_cnt_d  = byte_cnt_q + 4'd1;

            if (byte_cnt_q == '0) begin
              blk_sh_d = bus.RxSyncHeader;
              if (sh_good) begin
                blk_os_d  = (bus.RxSyncHeader == SH_OS);
                bad_run_d = '0;
                if ((state_q == ST_ALIGNED) && (bus.RxSyncHeader == SH_OS) &&
                    (bus.RxData == SDS_BYTE0)) begin
                  state_d = ST_LOCKED;
                end
              end else begin
                blk_os_d   = 1'b0;
                sh_error_d = 1'b1;
                err_cnt_d  = err_cnt_inc;
                if (bad_run_inc == ERR_LIM_C) begin
                  state_d    = ST_UNALIGNED;
                  byte_cnt_d = '0;
                  bad_run_d  = '0;
                end else begin
                  bad_run_d  = bad_run_inc;
                end
              end
            end
          end
        end

        default: begin
          state_d      = ST_UNALIGNED;
          byte_cnt_d   = '0;
          bad_run_d    = '0;
          chk_active_d = 1'b0;
        end
      endcase
    end

    aligned_d = (state_d != ST_UNALIGNED);
    locked_d  = (state_d == ST_LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_UNALIGNED;
      byte_cnt_q   <= '0;
      bad_run_q    <= '0;
      chk_active_q <= 1'b0;
      blk_data_q   <= '0;
      blk_valid_q  <= 1'b0;
      blk_start_q  <= 1'b0;
      blk_os_q     <= 1'b0;
      blk_sh_q     <= '0;
      aligned_q    <= 1'b0;
      locked_q     <= 1'b0;
      sh_error_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      bad_run_q    <= bad_run_d;
      chk_active_q <= chk_active_d;
      blk_data_q   <= blk_data_d;
      blk_valid_q  <= blk_valid_d;
      blk_start_q  <= blk_start_d;
      blk_os_q     <= blk_os_d;
      blk_sh_q     <= blk_sh_d;
      aligned_q    <= aligned_d;
      locked_q     <= locked_d;
      sh_error_q   <= sh_error_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign bus.blk_data  = blk_data_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.blk_start = blk_start_q;
  assign bus.blk_os    = blk_os_q;
  assign bus.blk_sh    = blk_sh_q;
  assign bus.aligned   = aligned_q;
  assign bus.locked    = locked_q;
  assign bus.sh_error  = sh_error_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
